// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture path: FSM encoding, RGB565 bit
// positions and RGB111 colour constants.
package cam_pkg;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    LINE       = 2'd1,
    PIX_LO     = 2'd2
  } cam_state_e;

  // Bit taken from each RGB565 byte for the reduced pixel
  localparam int unsigned R_MSB = 7;  // of the high byte
  localparam int unsigned G_MSB = 2;  // of the high byte
  localparam int unsigned B_MSB = 4;  // of the low byte

  localparam int unsigned RGBW = 3;
  localparam logic [RGBW-1:0] RED   = 3'b100;
  localparam logic [RGBW-1:0] GREEN = 3'b010;
  localparam logic [RGBW-1:0] BLUE  = 3'b001;

  // Column / line counter widths
  localparam int unsigned XW = 10;
  localparam int unsigned YW = 9;

  function automatic logic [XW-1:0] x_sat_inc(input logic [XW-1:0] x);
    return (x == {XW{1'b1}}) ? x : x + XW'(1);
  endfunction

  function automatic logic [YW-1:0] y_sat_inc(input logic [YW-1:0] y);
    return (y == {YW{1'b1}}) ? y : y + YW'(1);
  endfunction

endpackage

// File: rtl/cam_rgb565_to_rgb111.sv
// Combinational RGB565 byte pair to RGB111 reduction (top bit of each channel).
module cam_rgb565_to_rgb111
  import cam_pkg::*;
(
  input  logic [7:0]      hi_i,
  input  logic [7:0]      lo_i,
  output logic [RGBW-1:0] rgb_o
);

  assign rgb_o = {hi_i[R_MSB], hi_i[G_MSB], lo_i[B_MSB]};

  // Remaining channel bits are intentionally discarded
  logic unused_bits;
  assign unused_bits = ^{hi_i, lo_i};

endmodule

// File: rtl/cam_capture_rgb111.sv
// OV7670-style RGB565 byte stream to RGB111 frame-buffer writer.
// Optional single-frame snapshot mode: CAM_CAPTURE_SNAPSHOT_EN.
module cam_capture_rgb111
  import cam_pkg::*;
#(
  parameter int unsigned CAM_SCREEN_X = 256,
  parameter int unsigned CAM_SCREEN_Y = 256,
  parameter int unsigned AW           = 16,
  parameter int unsigned DW           = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cam_vsync,
  input  logic          cam_href,
  input  logic [7:0]    cam_data,
  input  logic          snap,
  output logic [AW-1:0] addr_in,
  output logic [DW-1:0] data_in,
  output logic          regwrite,
  output logic          frame_done,
  output logic          busy
);

  cam_state_e    state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [7:0]    hi_q, hi_d;
  logic          vsync_q;
  logic          vs_valid_q;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          we_q, we_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          armed;

  logic [RGBW-1:0] rgb;
  logic            vs_fall;
  logic            vs_rise;
  logic            in_window;

  cam_rgb565_to_rgb111 u_conv (
    .hi_i  (hi_q),
    .lo_i  (cam_data),
    .rgb_o (rgb)
  );

  // vsync_q resets high, so the first post-reset sample must not count as an edge
  assign vs_fall = vs_valid_q & vsync_q & ~cam_vsync;
  assign vs_rise = vs_valid_q & ~vsync_q & cam_vsync;

  assign in_window = (32'(x_q) < CAM_SCREEN_X) && (32'(y_q) < CAM_SCREEN_Y);

`ifdef CAM_CAPTURE_SNAPSHOT_EN
  logic armed_q, armed_d;
  assign armed = armed_q;
`else
  logic unused_snap;
  assign armed       = 1'b1;
  assign unused_snap = snap;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    busy_d  = busy_q;
`ifdef CAM_CAPTURE_SNAPSHOT_EN
    armed_d = armed_q;
`endif

    case (state_q)
      WAIT_FRAME: begin
`ifdef CAM_CAPTURE_SNAPSHOT_EN
        if (snap) armed_d = 1'b1;
`endif
        if (vs_fall && armed) begin
          state_d = LINE;
          x_d     = '0;
          y_d     = '0;
          busy_d  = 1'b1;
`ifdef CAM_CAPTURE_SNAPSHOT_EN
          armed_d = 1'b0;
`endif
        end
      end

      LINE: begin
        if (vs_rise) begin
          state_d = WAIT_FRAME;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (cam_href) begin
          hi_d    = cam_data;
          state_d = PIX_LO;
        end else if (x_q != '0) begin
          x_d = '0;
          y_d = y_sat_inc(y_q);
        end
      end

      PIX_LO: begin
        state_d = LINE;
        if (vs_rise) begin
          state_d = WAIT_FRAME;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (cam_href) begin
          if (in_window) begin
            we_d   = 1'b1;
            data_d = DW'(rgb);
            addr_d = AW'(32'(y_q) * CAM_SCREEN_X + 32'(x_q));
          end
          x_d = x_sat_inc(x_q);
        end else if (x_q != '0) begin
          // Odd byte count: the dangling high byte is dropped
          x_d = '0;
          y_d = y_sat_inc(y_q);
        end
      end

      default: begin
        state_d = WAIT_FRAME;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= WAIT_FRAME;
      x_q        <= '0;
      y_q        <= '0;
      hi_q       <= '0;
      vsync_q    <= 1'b1;
      vs_valid_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      hi_q       <= hi_d;
      vsync_q    <= cam_vsync;
      vs_valid_q <= 1'b1;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

`ifdef CAM_CAPTURE_SNAPSHOT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) armed_q <= 1'b0;
    else      armed_q <= armed_d;
  end
`endif

  assign addr_in    = addr_q;
  assign data_in    = data_q;
  assign regwrite   = we_q;
  assign frame_done = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_cam_capture_rgb111.sv
// Randomized bench for cam_capture_rgb111: a frame-level model predicts every
// buffer write (address, data, cycle) and every frame_done pulse.
`timescale 1ns/1ps
module tb_cam_capture_rgb111;
  import cam_pkg::*;

  localparam int unsigned SX = 256;
  localparam int unsigned SY = 256;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 3;
`ifdef CAM_CAPTURE_SNAPSHOT_EN
  localparam bit SNAP_MODE = 1'b1;
`else
  localparam bit SNAP_MODE = 1'b0;
`endif

  logic          clk       = 1'b0;
  logic          rst       = 1'b0;
  logic          cam_vsync = 1'b0;
  logic          cam_href  = 1'b0;
  logic [7:0]    cam_data  = 8'h00;
  logic          snap      = 1'b0;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] data_in;
  logic          regwrite;
  logic          frame_done;
  logic          busy;

  cam_capture_rgb111 #(
    .CAM_SCREEN_X (SX),
    .CAM_SCREEN_Y (SY),
    .AW           (AW),
    .DW           (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .snap       (snap),
    .addr_in    (addr_in),
    .data_in    (data_in),
    .regwrite   (regwrite),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned   cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t         exp_wr[$];
  int unsigned exp_done[$];
  int unsigned line_bytes[$];
  int          checks = 0;
  int          errors = 0;
  bit          armed;
  bit          rnd_mode;
  logic [7:0]  fix_hi, fix_lo;
  int unsigned gap_max = 2;
  logic [AW-1:0] last_addr = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rgb_of(input logic [7:0] hi, input logic [7:0] lo);
    logic [DW-1:0] c;
    c = '0;
    if (hi[7]) c |= RED;
    if (hi[2]) c |= GREEN;
    if (lo[4]) c |= BLUE;
    return c;
  endfunction

  function automatic logic [7:0] next_byte(input bit is_hi);
    if (rnd_mode) return 8'($urandom);
    return is_hi ? fix_hi : fix_lo;
  endfunction

  // Output monitor: every write / frame_done must match the model's cycle
  always @(negedge clk) begin : mon
    bit wr_now;
    bit dn_now;
    if (rst) begin
      wr_now = (exp_wr.size() > 0) && (exp_wr[0].cyc == cyc);
      if (regwrite || wr_now) begin
        check("regwrite", 32'(regwrite), 32'(wr_now));
        if (wr_now) begin
          check("wr_addr", 32'(addr_in), 32'(exp_wr[0].addr));
          check("wr_data", 32'(data_in), 32'(exp_wr[0].data));
          void'(exp_wr.pop_front());
        end
      end
      if (regwrite) last_addr = addr_in;
      dn_now = (exp_done.size() > 0) && (exp_done[0] == cyc);
      if (frame_done || dn_now) begin
        check("frame_done", 32'(frame_done), 32'(dn_now));
        if (dn_now) void'(exp_done.pop_front());
      end
    end
  end

  task automatic drive(input logic vs, input logic hr, input logic [7:0] d);
    @(negedge clk);
    cam_vsync = vs;
    cam_href  = hr;
    cam_data  = d;
    snap      = 1'b0;
  endtask

  task automatic do_snap();
    @(negedge clk);
    cam_vsync = 1'b1;
    cam_href  = 1'b0;
    snap      = 1'b1;
    if (SNAP_MODE) armed = 1'b1;
  endtask

  // One frame from line_bytes; abort ends it with vsync rising mid-pixel
  task automatic send_frame(input bit abort);
    bit          cap;
    int unsigned y;
    int unsigned nb;
    logic [7:0]  hi, lo;
    wr_t         e;
    cap = armed;
    hi  = 8'h00;
    repeat (3) drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    if (SNAP_MODE && cap) armed = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    check("busy_start", 32'(busy), 32'(cap));
    y = 0;
    foreach (line_bytes[l]) begin
      nb = line_bytes[l];
      for (int b = 0; b < int'(nb); b++) begin
        if (b % 2 == 0) begin
          hi = next_byte(1'b1);
          drive(1'b0, 1'b1, hi);
        end else begin
          lo = next_byte(1'b0);
          drive(1'b0, 1'b1, lo);
          if (cap && (b / 2) < int'(SX) && y < SY) begin
            e.cyc  = cyc + 1;
            e.addr = AW'(y * SX + 32'(b / 2));
            e.data = rgb_of(hi, lo);
            exp_wr.push_back(e);
          end
        end
      end
      if (nb >= 2) y++;
      repeat ($urandom_range(1, gap_max)) drive(1'b0, 1'b0, 8'h00);
    end
    if (abort) begin
      drive(1'b0, 1'b1, next_byte(1'b1));
      drive(1'b1, 1'b1, next_byte(1'b0));
    end else begin
      drive(1'b1, 1'b0, 8'h00);
    end
    if (cap) exp_done.push_back(cyc + 1);
    drive(1'b1, 1'b0, 8'h00);
    check("busy_end", 32'(busy), 32'(0));
  endtask

  task automatic reset_mid_frame();
    wr_t e;
    do_snap();
    line_bytes.delete();
    repeat (3) drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    for (int p = 0; p < 2; p++) begin
      drive(1'b0, 1'b1, 8'hFF);
      drive(1'b0, 1'b1, 8'hFF);
      if (armed) begin
        e.cyc  = cyc + 1;
        e.addr = AW'(p);
        e.data = 3'b111;
        exp_wr.push_back(e);
      end
    end
    drive(1'b0, 1'b1, 8'hFF);
    drive(1'b0, 1'b1, 8'hFF);
    @(negedge clk);
    cam_data = 8'hFF;
    rst      = 1'b0;
    #1;
    check("midrst_addr", 32'(addr_in), 32'(0));
    check("midrst_data", 32'(data_in), 32'(0));
    check("midrst_we", 32'(regwrite), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    rst   = 1'b1;
    armed = !SNAP_MODE;
  endtask

  initial begin
    armed    = !SNAP_MODE;
    rnd_mode = 1'b1;
    fix_hi   = 8'h00;
    fix_lo   = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(addr_in), 32'(0));
    check("rst_data", 32'(data_in), 32'(0));
    check("rst_we", 32'(regwrite), 32'(0));
    check("rst_done", 32'(frame_done), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));

    // Released with vsync already low: bytes must be ignored
    rst = 1'b1;
    for (int i = 0; i < 10; i++) drive(1'b0, 1'(i % 5 != 4), 8'($urandom));
    check("busy_vs_low", 32'(busy), 32'(0));

    // 2 lines x 4 red pixels
    do_snap();
    rnd_mode = 1'b0; fix_hi = 8'hF8; fix_lo = 8'h00;
    line_bytes = '{8, 8};
    send_frame(1'b0);

    // 300-pixel green line, only 256 stored
    do_snap();
    fix_hi = 8'h07; fix_lo = 8'hE0;
    line_bytes = '{600};
    send_frame(1'b0);

    // 260 lines; line 255 is full width so the last write hits 65535
    do_snap();
    rnd_mode = 1'b1; gap_max = 1;
    line_bytes.delete();
    for (int l = 0; l < 260; l++) line_bytes.push_back(l == 255 ? 512 : (l < 255 ? 2 : 4));
    last_addr = '0;
    send_frame(1'b0);
    check("last_addr", 32'(last_addr), 32'(65535));

    // Odd byte count line followed by an even one, blue
    do_snap();
    rnd_mode = 1'b0; fix_hi = 8'h00; fix_lo = 8'h1F; gap_max = 3;
    line_bytes = '{9, 8};
    send_frame(1'b0);

    // vsync rises together with a low byte
    do_snap();
    rnd_mode = 1'b1;
    line_bytes = '{6, 5};
    send_frame(1'b1);

    reset_mid_frame();

    for (int f = 0; f < 4; f++) begin
      do_snap();
      line_bytes.delete();
      repeat ($urandom_range(1, 4)) line_bytes.push_back($urandom_range(2, 24));
      send_frame(1'($urandom_range(0, 1)));
    end

    // Frames without a snap: captured only when snapshot mode is off
    line_bytes = '{8, 10};
    send_frame(1'b0);
    do_snap();
    send_frame(1'b0);
    send_frame(1'b0);

    repeat (4) drive(1'b1, 1'b0, 8'h00);
    check("wr_pending", 32'(exp_wr.size()), 32'(0));
    check("done_pending", 32'(exp_done.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout got=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
